cv_csmem_ctlreg_bank: RTL and testbench
=======================================

// Module: cv_csmem_ctlreg_bank
// PURPOSE
//  Parametrised CPU-visible control register bank on the ps_c slave bus. It holds the render-order table, sprite count and VIRQ control.
//  Adds over the previous generation: sticky W1C interrupt status, a frame counter, and frame-synchronous commit of shadowed config.
//  Sits between the PS slave decoder and the renderer/sprite engine; one instance per ADDR_MSB window.
// PARAMETERS
//  ADDR_MSB     7'b111_1101  match value for ps_c_addr[18:12]
//  NUM_ORDER    8            render-order entries; multiple of 4, range 4..32
//  SP_CNT_W     16           sprite-count register width, 1..32
//  FRAME_CNT_W  16           frame counter width, 1..32
// PORTS
//  ps_c_clk         in   1                   single clock
//  reset_n          in   1                   asynchronous, active-low reset
//  ps_c_addr        in   19                  byte address; word index = ps_c_addr[11:2]
//  ps_c_din         in   32                  write data
//  ps_c_we          in   4                   byte write enables
//  ps_c_en          in   1                   access strobe
//  ps_c_dout        out  32                  read data, registered
//  ps_c_dout_en     out  1                   read data valid, 1 cycle after cs
//  frame_start      in   1                   1-cycle pulse at the frame boundary
//  rend_order_sel   in   $clog2(NUM_ORDER)   render-order entry select
//  r_rend_order     out  8                   active entry[rend_order_sel], combinational
//  r_sp_count       out  SP_CNT_W            active sprite count
//  r_virq_en        out  1                   VIRQ enable bit
//  r_virq_trig      out  1                   software trigger pulse, combinational from the write
//  r_irq            out  1                   registered: virq_en & irq_pending
// BEHAVIOUR
//  cs = (ps_c_addr[18:12]==ADDR_MSB) & ps_c_en. Word map (index = addr[11:2]):
//   0x000 CTRL    RW  b0 virq_en; b1 write-1 = commit_req; b1 reads commit_pending
//   0x001 STAT    b0 irq_pending (W1C); b1 commit_pending (RO)
//   0x004 TRIG    WO  write with we[0] & din[0] -> r_virq_trig=1 that same cycle
//   0x008+k, k<NUM_ORDER/4  ORDER shadow: byte j (we[j]) = entry 4k+j
//   0x010 SPCNT   RW  shadow sprite count; written only when all we lanes covering SP_CNT_W are set
//   0x011 FRAME   RO  frame counter, zero-extended
//  - Reads: 1-cycle latency. dout_en <= cs. dout updates only when cs; it holds otherwise.
//  - Reads of unmapped words, and of WO words, return 0. ORDER and SPCNT reads return the shadow value.
//  - frame_start:
//    - sets irq_pending.
//    - increments the frame counter; it wraps to 0 at all-ones.
//    - if commit_pending: copies shadow -> active, then clears commit_pending.
//  - Simultaneous events:
//    - W1C of irq_pending in the same cycle as frame_start: pending stays 1 (set wins).
//    - commit_req in the same cycle as frame_start: this frame_start does not apply the request; pending is set and the commit happens at the next frame_start.
//    - A shadow write in the same cycle as a commit: the active copy takes the old shadow; the new value lands in the shadow.
//  - Active-table writes happen only through commit. The renderer never sees a torn table.
//  - Reset (any time, including mid-frame or with a commit pending) clears:
//    - all shadow/active regs, virq_en, irq_pending, commit_pending, the frame counter;
//    - dout=0, dout_en=0, r_irq=0.
//  - Writes with ps_c_we=0 have no effect. A read access never changes state.
// CONFIGURATION
//  `CV_CSMEM_DBUF_EN defined: shadow/active double buffering as above.
//  Not defined: no active copy.
//   - Writes update the outputs on the next clock.
//   - commit_req is ignored; commit_pending reads 0.
//   - frame_start only sets irq_pending and counts frames.
// STRUCTURE
//  Shared package/include cv_csmem_defs.vh:
//   - register word offsets (CTRL/STAT/TRIG/ORDER_BASE/SPCNT/FRAME);
//   - CTRL/STAT bit positions;
//   - ADDR_MSB constants for each window.
//  Sub-module cv_csmem_order_bank (NUM_ORDER x 8 shadow+active storage, byte-lane write, commit, select mux).
//   Sprite count and control stay in the top.
// TESTING
//  1 Reset/readback: deassert reset_n; read 0x000,0x001,0x008,0x010,0x011 -> all 0, dout_en exactly 1 cycle after each cs.
//  2 Commit (DBUF): write 0x008=0x44332211, we=4'b0101, then 0x000=0x3.
//    -> r_rend_order[sel=0]=0 and STAT=0x2 until frame_start.
//    -> next cycle: entry0=0x11, entry2=0x33, entry1=0, STAT b1=0.
//  3 IRQ: virq_en=1, pulse frame_start -> r_irq=1 next cycle.
//    -> W1C 0x001=0x1 alone -> r_irq=0.
//    -> W1C coincident with frame_start -> r_irq stays 1.
//  4 Race: commit_req on the same cycle as frame_start -> no copy. Pulse frame_start again -> copy occurs, FRAME reads 2.
//  5 Wrap: FRAME_CNT_W=4, 16 frame_start pulses -> FRAME=0. Unmapped read of 0x3FF -> 0. TRIG write -> r_virq_trig 1 cycle.
//  6 No-DBUF build: write SPCNT=0x0123 -> r_sp_count=0x0123 next cycle, with no frame_start.

Source files
------------

// File: rtl/cv_csmem_pkg.sv
// ---------------------------------------------------------------------------
// cv_csmem_pkg
// Shared definitions for the ps_c control-register windows:
//   - word offsets of every register (index = ps_c_addr[11:2])
//   - CTRL / STAT bit positions
//   - ADDR_MSB window constants
//   - register-kind enum and the word decoder used by the bank top
// ---------------------------------------------------------------------------
package cv_csmem_pkg;

    // Window select value for ps_c_addr[18:12]
    localparam logic [6:0] ADDR_MSB_CTLREG = 7'b111_1101;

    // Word offsets
    localparam logic [9:0] REG_CTRL       = 10'h000;
    localparam logic [9:0] REG_STAT       = 10'h001;
    localparam logic [9:0] REG_TRIG       = 10'h004;
    localparam logic [9:0] REG_ORDER_BASE = 10'h008;
    localparam logic [9:0] REG_SPCNT      = 10'h010;
    localparam logic [9:0] REG_FRAME      = 10'h011;

    // CTRL / STAT bit positions
    localparam int CTRL_VIRQ_EN_BIT = 0;
    localparam int CTRL_COMMIT_BIT  = 1;
    localparam int STAT_IRQ_BIT     = 0;
    localparam int STAT_COMMIT_BIT  = 1;

    typedef enum logic [2:0] {
        KIND_NONE,
        KIND_CTRL,
        KIND_STAT,
        KIND_TRIG,
        KIND_ORDER,
        KIND_SPCNT,
        KIND_FRAME
    } reg_kind_e;

    // Classifies a word index; the ORDER range depends on how many
    // 4-entry words the instance has.
    function automatic reg_kind_e decode_word(input logic [9:0] word,
                                              input int         order_words);
        reg_kind_e kind;
        kind = KIND_NONE;
        if (word == REG_CTRL)
            kind = KIND_CTRL;
        else if (word == REG_STAT)
            kind = KIND_STAT;
        else if (word == REG_TRIG)
            kind = KIND_TRIG;
        else if (word == REG_SPCNT)
            kind = KIND_SPCNT;
        else if (word == REG_FRAME)
            kind = KIND_FRAME;
        else if ((word >= REG_ORDER_BASE) &&
                 (word <  REG_ORDER_BASE + 10'(order_words)))
            kind = KIND_ORDER;
        return kind;
    endfunction

endpackage

// File: rtl/cv_csmem_order_bank.sv
// ---------------------------------------------------------------------------
// cv_csmem_order_bank
// NUM_ORDER x 8-bit render-order storage: byte-lane writable shadow table,
// optional active copy loaded on commit, and the renderer select mux.
// Build option: `CV_CSMEM_DBUF_EN keeps a separate active table; without it
// the renderer reads the shadow table directly.
// Ports:
//   ps_c_clk, reset_n  clock, async active-low reset
//   wr_en              write strobe for a word inside the ORDER range
//   word_off           word offset relative to the ORDER base
//   wr_lanes, wr_data  byte enables / data; lane j -> entry 4*word_off+j
//   commit             copy shadow -> active (double-buffered build only)
//   sel                render-order entry select
//   rd_data            shadow word at word_off (for bus reads)
//   order_out          active (or shadow) entry[sel], combinational
// ---------------------------------------------------------------------------
module cv_csmem_order_bank #(
    parameter int NUM_ORDER = 8
) (
    input  logic                         ps_c_clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [9:0]                   word_off,
    input  logic [3:0]                   wr_lanes,
    input  logic [31:0]                  wr_data,
    input  logic                         commit,
    input  logic [$clog2(NUM_ORDER)-1:0] sel,
    output logic [31:0]                  rd_data,
    output logic [7:0]                   order_out
);

    localparam int NUM_WORDS = NUM_ORDER / 4;

    logic [7:0] shadow [NUM_ORDER];

    // Shadow table: each byte lane of the addressed word updates one entry.
    always_ff @(posedge ps_c_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ORDER; i++)
                shadow[i] <= '0;
        end else if (wr_en) begin
            for (int g = 0; g < NUM_WORDS; g++) begin
                if (word_off == 10'(g)) begin
                    for (int j = 0; j < 4; j++) begin
                        if (wr_lanes[j])
                            shadow[4*g+j] <= wr_data[8*j +: 8];
                    end
                end
            end
        end
    end

    // Bus readback always returns the shadow contents.
    always_comb begin
        rd_data = '0;
        for (int g = 0; g < NUM_WORDS; g++) begin
            if (word_off == 10'(g))
                rd_data = {shadow[4*g+3], shadow[4*g+2], shadow[4*g+1], shadow[4*g]};
        end
    end

`ifdef CV_CSMEM_DBUF_EN
    logic [7:0] active [NUM_ORDER];

    // The whole table is copied in one edge, so the renderer never observes
    // a mix of old and new entries. A coincident shadow write lands only in
    // the shadow because the copy samples the pre-edge shadow.
    always_ff @(posedge ps_c_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ORDER; i++)
                active[i] <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_ORDER; i++)
                active[i] <= shadow[i];
        end
    end

    always_comb begin
        order_out = '0;
        if (int'(sel) < NUM_ORDER)
            order_out = active[sel];
    end
`else
    logic unused_commit;
    assign unused_commit = commit;

    always_comb begin
        order_out = '0;
        if (int'(sel) < NUM_ORDER)
            order_out = shadow[sel];
    end
`endif

endmodule

// File: rtl/cv_csmem_ctlreg_bank.sv
// ---------------------------------------------------------------------------
// cv_csmem_ctlreg_bank
// CPU-visible control register bank on the ps_c slave bus: render-order
// table, sprite count, VIRQ control, sticky W1C interrupt status, frame
// counter and frame-synchronous commit of shadowed configuration.
// Build option: `CV_CSMEM_DBUF_EN enables shadow/active double buffering.
// Without it, writes reach r_rend_order/r_sp_count on the next clock,
// commit requests are ignored and commit_pending reads 0.
// Ports:
//   ps_c_clk, reset_n         clock, async active-low reset
//   ps_c_addr/din/we/en       slave bus access (word index = addr[11:2])
//   ps_c_dout, ps_c_dout_en   registered read data / valid (1 cycle after cs)
//   frame_start               1-cycle frame boundary pulse
//   rend_order_sel            render-order entry select
//   r_rend_order              selected active entry, combinational
//   r_sp_count                active sprite count
//   r_virq_en                 VIRQ enable
//   r_virq_trig               software trigger, combinational from TRIG write
//   r_irq                     registered virq_en & irq_pending
// ---------------------------------------------------------------------------
module cv_csmem_ctlreg_bank
    import cv_csmem_pkg::*;
#(
    parameter logic [6:0] ADDR_MSB    = ADDR_MSB_CTLREG,
    parameter int         NUM_ORDER   = 8,
    parameter int         SP_CNT_W    = 16,
    parameter int         FRAME_CNT_W = 16
) (
    input  logic                         ps_c_clk,
    input  logic                         reset_n,
    input  logic [18:0]                  ps_c_addr,
    input  logic [31:0]                  ps_c_din,
    input  logic [3:0]                   ps_c_we,
    input  logic                         ps_c_en,
    output logic [31:0]                  ps_c_dout,
    output logic                         ps_c_dout_en,
    input  logic                         frame_start,
    input  logic [$clog2(NUM_ORDER)-1:0] rend_order_sel,
    output logic [7:0]                   r_rend_order,
    output logic [SP_CNT_W-1:0]          r_sp_count,
    output logic                         r_virq_en,
    output logic                         r_virq_trig,
    output logic                         r_irq
);

    localparam int         SP_LANE_CNT  = (SP_CNT_W + 7) / 8;
    localparam logic [3:0] SP_LANE_MASK = 4'((1 << SP_LANE_CNT) - 1);

    logic                   cs;
    logic [9:0]             word_idx;
    reg_kind_e              kind;
    logic                   ctrl_wr;
    logic                   irq_clr;
    logic                   sp_wr;
    logic                   order_wr;
    logic                   commit_pending;
    logic                   commit;
    logic                   virq_en;
    logic                   irq_pending;
    logic [SP_CNT_W-1:0]    sp_shadow;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [31:0]            order_rd_data;
    logic [31:0]            rdata;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^ps_c_addr[1:0];

    assign cs       = (ps_c_addr[18:12] == ADDR_MSB) & ps_c_en;
    assign word_idx = ps_c_addr[11:2];
    assign kind     = decode_word(word_idx, NUM_ORDER / 4);

    // Control and status bits all live in byte lane 0.
    assign ctrl_wr  = cs & (kind == KIND_CTRL) & ps_c_we[0];
    assign irq_clr  = cs & (kind == KIND_STAT) & ps_c_we[0] & ps_c_din[STAT_IRQ_BIT];
    assign order_wr = cs & (kind == KIND_ORDER) & (|ps_c_we);
    // A partial write could tear the sprite count, so every lane that holds
    // count bits must be enabled.
    assign sp_wr    = cs & (kind == KIND_SPCNT) & ((ps_c_we & SP_LANE_MASK) == SP_LANE_MASK);

    assign r_virq_trig = cs & (kind == KIND_TRIG) & ps_c_we[0] & ps_c_din[0];
    assign r_virq_en   = virq_en;

    cv_csmem_order_bank #(
        .NUM_ORDER (NUM_ORDER)
    ) u_order_bank (
        .ps_c_clk  (ps_c_clk),
        .reset_n   (reset_n),
        .wr_en     (order_wr),
        .word_off  (word_idx - REG_ORDER_BASE),
        .wr_lanes  (ps_c_we),
        .wr_data   (ps_c_din),
        .commit    (commit),
        .sel       (rend_order_sel),
        .rd_data   (order_rd_data),
        .order_out (r_rend_order)
    );

`ifdef CV_CSMEM_DBUF_EN
    logic                commit_req;
    logic [SP_CNT_W-1:0] sp_active;

    assign commit_req = ctrl_wr & ps_c_din[CTRL_COMMIT_BIT];
    assign commit     = frame_start & commit_pending;
    assign r_sp_count = sp_active;

    // A request arriving with frame_start is held for the following frame,
    // so it takes priority over the clear caused by this frame_start.
    always_ff @(posedge ps_c_clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_pending <= 1'b0;
            sp_active      <= '0;
        end else begin
            if (commit_req)
                commit_pending <= 1'b1;
            else if (frame_start)
                commit_pending <= 1'b0;
            if (commit)
                sp_active <= sp_shadow;
        end
    end
`else
    assign commit_pending = 1'b0;
    assign commit         = 1'b0;
    assign r_sp_count     = sp_shadow;
`endif

    // Bus readback; write-only and unmapped words read as zero.
    always_comb begin
        rdata = '0;
        case (kind)
            KIND_CTRL: begin
                rdata[CTRL_VIRQ_EN_BIT] = virq_en;
                rdata[CTRL_COMMIT_BIT]  = commit_pending;
            end
            KIND_STAT: begin
                rdata[STAT_IRQ_BIT]    = irq_pending;
                rdata[STAT_COMMIT_BIT] = commit_pending;
            end
            KIND_ORDER: rdata = order_rd_data;
            KIND_SPCNT: rdata = 32'(sp_shadow);
            KIND_FRAME: rdata = 32'(frame_cnt);
            default:    rdata = '0;
        endcase
    end

    // Control/status registers, frame counter and registered bus outputs.
    // frame_start beats a coincident W1C so no interrupt is lost.
    always_ff @(posedge ps_c_clk or negedge reset_n) begin
        if (!reset_n) begin
            virq_en      <= 1'b0;
            irq_pending  <= 1'b0;
            sp_shadow    <= '0;
            frame_cnt    <= '0;
            ps_c_dout    <= '0;
            ps_c_dout_en <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (ctrl_wr)
                virq_en <= ps_c_din[CTRL_VIRQ_EN_BIT];
            if (frame_start)
                irq_pending <= 1'b1;
            else if (irq_clr)
                irq_pending <= 1'b0;
            if (sp_wr)
                sp_shadow <= ps_c_din[SP_CNT_W-1:0];
            if (frame_start)
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            ps_c_dout_en <= cs;
            if (cs)
                ps_c_dout <= rdata;
            r_irq <= virq_en & irq_pending;
        end
    end

endmodule

// File: tb/tb_cv_csmem_ctlreg_bank.sv
// ---------------------------------------------------------------------------
// tb_cv_csmem_ctlreg_bank
// Self-checking bench: directed scenarios plus random bus traffic, all
// compared against a register-level behavioural model of the bank.
// ---------------------------------------------------------------------------
module tb_cv_csmem_ctlreg_bank;

    localparam int         NUM_ORDER   = 8;
    localparam int         SP_CNT_W    = 16;
    localparam int         FRAME_CNT_W = 4;
    localparam int         FRAME_MOD   = 1 << FRAME_CNT_W;
    localparam logic [6:0] WIN         = 7'b111_1101;
`ifdef CV_CSMEM_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic                ps_c_clk;
    logic                reset_n;
    logic [18:0]         ps_c_addr;
    logic [31:0]         ps_c_din;
    logic [3:0]          ps_c_we;
    logic                ps_c_en;
    logic [31:0]         ps_c_dout;
    logic                ps_c_dout_en;
    logic                frame_start;
    logic [2:0]          rend_order_sel;
    logic [7:0]          r_rend_order;
    logic [SP_CNT_W-1:0] r_sp_count;
    logic                r_virq_en;
    logic                r_virq_trig;
    logic                r_irq;

    cv_csmem_ctlreg_bank #(
        .ADDR_MSB    (WIN),
        .NUM_ORDER   (NUM_ORDER),
        .SP_CNT_W    (SP_CNT_W),
        .FRAME_CNT_W (FRAME_CNT_W)
    ) dut (
        .ps_c_clk       (ps_c_clk),
        .reset_n        (reset_n),
        .ps_c_addr      (ps_c_addr),
        .ps_c_din       (ps_c_din),
        .ps_c_we        (ps_c_we),
        .ps_c_en        (ps_c_en),
        .ps_c_dout      (ps_c_dout),
        .ps_c_dout_en   (ps_c_dout_en),
        .frame_start    (frame_start),
        .rend_order_sel (rend_order_sel),
        .r_rend_order   (r_rend_order),
        .r_sp_count     (r_sp_count),
        .r_virq_en      (r_virq_en),
        .r_virq_trig    (r_virq_trig),
        .r_irq          (r_irq)
    );

    initial ps_c_clk = 1'b0;
    always #5 ps_c_clk = ~ps_c_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit                  m_virq_en, m_irq_pend, m_commit_pend, m_dout_en, m_irq;
    logic [31:0]         m_dout;
    logic [7:0]          m_shadow [NUM_ORDER];
    logic [7:0]          m_active [NUM_ORDER];
    logic [SP_CNT_W-1:0] m_sp_shadow, m_sp_active;
    int                  m_frame;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] addrOf(input int word);
        return {WIN, 10'(word), 2'b00};
    endfunction

    function automatic logic [31:0] modelRead(input int word);
        int k;
        if (word == 0)  return {30'b0, m_commit_pend, m_virq_en};
        if (word == 1)  return {30'b0, m_commit_pend, m_irq_pend};
        if (word >= 8 && word < 8 + NUM_ORDER/4) begin
            k = word - 8;
            return {m_shadow[4*k+3], m_shadow[4*k+2], m_shadow[4*k+1], m_shadow[4*k]};
        end
        if (word == 16) return 32'(m_sp_shadow);
        if (word == 17) return 32'(m_frame);
        return 32'h0;
    endfunction

    function automatic logic [7:0] expOrder(input int sel);
        return DBUF ? m_active[sel] : m_shadow[sel];
    endfunction

    function automatic logic [SP_CNT_W-1:0] expSp();
        return DBUF ? m_sp_active : m_sp_shadow;
    endfunction

    task automatic modelReset();
        m_virq_en = 0; m_irq_pend = 0; m_commit_pend = 0; m_dout_en = 0; m_irq = 0;
        m_dout = '0; m_sp_shadow = '0; m_sp_active = '0; m_frame = 0;
        for (int i = 0; i < NUM_ORDER; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
    endtask

    // One clock edge of the register bank's documented behaviour.
    task automatic modelStep(input logic [18:0] a, input logic [31:0] d, input logic [3:0] w,
                             input logic e, input logic fs);
        bit                  hit, creq, clr, n_virq, n_pend, n_irqp;
        int                  word;
        logic [31:0]         rd;
        logic [7:0]          n_shadow [NUM_ORDER];
        logic [7:0]          n_active [NUM_ORDER];
        logic [SP_CNT_W-1:0] n_sp_shadow, n_sp_active;
        hit  = e && (a[18:12] == WIN);
        word = int'(a[11:2]);
        rd   = modelRead(word);
        n_shadow = m_shadow;
        n_active = m_active;
        n_sp_shadow = m_sp_shadow;
        n_sp_active = m_sp_active;
        n_virq = m_virq_en;
        if (hit && w[0] && word == 0) n_virq = d[0];
        creq = DBUF && hit && w[0] && word == 0 && d[1];
        clr  = hit && w[0] && word == 1 && d[0];
        if (hit && word >= 8 && word < 8 + NUM_ORDER/4)
            for (int j = 0; j < 4; j++)
                if (w[j]) n_shadow[4*(word-8)+j] = d[8*j +: 8];
        if (hit && word == 16 && w[1:0] == 2'b11) n_sp_shadow = d[SP_CNT_W-1:0];
        if (DBUF && fs && m_commit_pend) begin
            n_active    = m_shadow;
            n_sp_active = m_sp_shadow;
        end
        n_pend = creq ? 1'b1 : (fs ? 1'b0 : m_commit_pend);
        n_irqp = fs ? 1'b1 : (clr ? 1'b0 : m_irq_pend);
        m_irq = m_virq_en && m_irq_pend;
        if (fs) m_frame = (m_frame + 1) % FRAME_MOD;
        m_dout_en = hit;
        if (hit) m_dout = rd;
        m_virq_en = n_virq;
        m_commit_pend = n_pend;
        m_irq_pend = n_irqp;
        m_shadow = n_shadow;
        m_active = n_active;
        m_sp_shadow = n_sp_shadow;
        m_sp_active = n_sp_active;
    endtask

    // Drives one cycle, checks combinational outputs before the edge and
    // registered outputs just after it.
    task automatic applyStimulus(input logic [18:0] a, input logic [31:0] d, input logic [3:0] w,
                                 input logic e, input logic fs, input logic [2:0] sel);
        bit exp_trig;
        ps_c_addr = a; ps_c_din = d; ps_c_we = w; ps_c_en = e;
        frame_start = fs; rend_order_sel = sel;
        #1;
        exp_trig = e && (a[18:12] == WIN) && (a[11:2] == 10'h004) && w[0] && d[0];
        checkOutput("order_pre", r_rend_order, expOrder(int'(sel)));
        checkOutput("trig", r_virq_trig, exp_trig);
        @(posedge ps_c_clk);
        modelStep(a, d, w, e, fs);
        #1;
        checkOutput("dout", ps_c_dout, m_dout);
        checkOutput("dout_en", ps_c_dout_en, m_dout_en);
        checkOutput("irq", r_irq, m_irq);
        checkOutput("virq_en", r_virq_en, m_virq_en);
        checkOutput("sp_count", r_sp_count, expSp());
        checkOutput("order_post", r_rend_order, expOrder(int'(sel)));
    endtask

    task automatic rdWord(input int word);
        applyStimulus(addrOf(word), 32'h0, 4'h0, 1'b1, 1'b0, 3'd0);
    endtask

    task automatic wrWord(input int word, input logic [31:0] d, input logic [3:0] w);
        applyStimulus(addrOf(word), d, w, 1'b1, 1'b0, 3'd0);
    endtask

    task automatic idle(input logic fs);
        applyStimulus(19'h0, 32'h0, 4'h0, 1'b0, fs, 3'd0);
    endtask

    task automatic doReset();
        ps_c_en = 0; ps_c_we = 0; frame_start = 0;
        reset_n = 1'b0;
        #2;
        modelReset();
        checkOutput("rst_dout", ps_c_dout, 32'h0);
        checkOutput("rst_dout_en", ps_c_dout_en, 1'b0);
        checkOutput("rst_irq", r_irq, 1'b0);
        checkOutput("rst_virq_en", r_virq_en, 1'b0);
        checkOutput("rst_sp_count", r_sp_count, '0);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        int words [10] = '{0, 1, 2, 4, 8, 9, 16, 17, 10'h3FF, 5};
        logic [18:0] a;
        logic [3:0]  w;
        reset_n = 1'b0;
        ps_c_addr = '0; ps_c_din = '0; ps_c_we = '0; ps_c_en = 0;
        frame_start = 0; rend_order_sel = '0;
        modelReset();
        @(posedge ps_c_clk);
        #1;
        doReset();

        $display("[TB] reset readback");
        rdWord(0); rdWord(1); rdWord(8); rdWord(16); rdWord(17);
        idle(1'b0);

        $display("[TB] commit sequence");
        wrWord(8, 32'h44332211, 4'b0101);
        wrWord(0, 32'h3, 4'b0001);
        rdWord(1);
        idle(1'b1);
        rend_order_sel = 3'd0; #1;
        checkOutput("t2_entry0", r_rend_order, 8'h11);
        rend_order_sel = 3'd1; #1;
        checkOutput("t2_entry1", r_rend_order, 8'h00);
        rend_order_sel = 3'd2; #1;
        checkOutput("t2_entry2", r_rend_order, 8'h33);
        rdWord(1);

        $display("[TB] irq handling");
        wrWord(0, 32'h1, 4'b0001);
        idle(1'b1); idle(1'b0);
        checkOutput("t3_irq_set", r_irq, 1'b1);
        wrWord(1, 32'h1, 4'b0001);
        idle(1'b0); idle(1'b0);
        checkOutput("t3_irq_clr", r_irq, 1'b0);
        applyStimulus(addrOf(1), 32'h1, 4'b0001, 1'b1, 1'b1, 3'd0);
        idle(1'b0); idle(1'b0);
        checkOutput("t3_irq_race", r_irq, 1'b1);

        $display("[TB] commit/frame race");
        doReset();
        wrWord(8, 32'hAABBCCDD, 4'b1111);
        applyStimulus(addrOf(0), 32'h2, 4'b0001, 1'b1, 1'b1, 3'd0);
        idle(1'b1);
        rdWord(17);
        checkOutput("t4_frame2", ps_c_dout, 32'h2);
        checkOutput("t4_entry0", r_rend_order, 8'hDD);

        $display("[TB] frame wrap, unmapped, trig");
        doReset();
        for (int i = 0; i < 16; i++) idle(1'b1);
        rdWord(17);
        checkOutput("t5_wrap", ps_c_dout, 32'h0);
        idle(1'b1);
        rdWord(17);
        checkOutput("t5_frame1", ps_c_dout, 32'h1);
        rdWord(10'h3FF);
        checkOutput("t5_unmapped", ps_c_dout, 32'h0);
        wrWord(4, 32'h1, 4'b0001);
        idle(1'b0);

        $display("[TB] sprite count");
        doReset();
        wrWord(16, 32'h0000_0123, 4'b0011);
        idle(1'b0);
        wrWord(16, 32'h0000_4567, 4'b0001);
        rdWord(16);

        $display("[TB] random traffic");
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) doReset();
            a = addrOf(words[$urandom_range(0, 9)]);
            if (a[11:2] == 10'd5) a[11:2] = 10'($urandom);
            a[1:0] = 2'($urandom);
            if ($urandom_range(0, 9) == 0) a[18:12] = 7'($urandom);
            w = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            applyStimulus(a, $urandom, w, ($urandom_range(0, 6) != 0),
                          ($urandom_range(0, 7) == 0), 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
